// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared MCU types and defaults for the instruction memory loader
package mcu_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 8;
  localparam int unsigned DATA_W_DEFAULT  = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;
  localparam int unsigned IMEM_DEPTH      = 2 ** ADDR_W_DEFAULT;
  localparam logic [DATA_W_DEFAULT-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN    = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    COMMIT = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and PC fetch port between host/MCU and the loader
interface imem_loader_if
  import mcu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instruction;

  modport master (
    output rx_data, rx_valid, pc,
    input  rx_ready, instruction
  );

  modport slave (
    input  rx_data, rx_valid, pc,
    output rx_ready, instruction
  );
endinterface

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - unreset instruction RAM, one synchronous write and one asynchronous read port
module imem_ram
  import mcu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle read of the address being written sees the pre-edge word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that fills the instruction RAM and gates core reset
module imem_loader
  import mcu_pkg::*;
#(
  parameter int unsigned       ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned       DATA_W         = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          load_done,
  output logic          load_error,
  output logic          busy
);

  localparam int unsigned REM_W  = ADDR_W + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REM_W-1:0]  FULL_LEN  = REM_W'(2 ** ADDR_W);

  loader_state_t     state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              core_hold_q, core_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic              busy_q, busy_d;

  logic accept;
  logic mem_we;
  logic in_frame;

  assign bus.rx_ready = (state_q != COMMIT) && !Reset;
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign in_frame     = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    addr_d       = addr_q;
    sum_d        = sum_q;
    csum_d       = csum_q;
    idle_d       = idle_q;
    core_hold_d  = core_hold_q;
    load_done_d  = 1'b0;
    load_error_d = load_error_q;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && (bus.rx_data == SYNC_BYTE)) begin
          state_d      = LEN;
          core_hold_d  = 1'b1;
          load_error_d = 1'b0;
          idle_d       = '0;
        end
      end
      LEN: begin
        if (accept) begin
          // A zero length byte stands for a full-depth image.
          rem_d   = (bus.rx_data == '0) ? FULL_LEN : REM_W'(bus.rx_data);
          addr_d  = '0;
          sum_d   = '0;
          idle_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          mem_we = 1'b1;
          addr_d = addr_q + 1'b1;
          sum_d  = sum_q + bus.rx_data;
          rem_d  = rem_q - 1'b1;
          idle_d = '0;
          if (rem_q == REM_W'(1)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          csum_d  = bus.rx_data;
          idle_d  = '0;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (sum_q == csum_q) begin
          load_done_d = 1'b1;
          core_hold_d = 1'b0;
        end else begin
          load_error_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stalled host inside a frame abandons it; written bytes stay in RAM.
    if (in_frame && !accept) begin
      if (idle_q == IDLE_LAST) begin
        state_d      = IDLE;
        load_error_d = 1'b1;
        core_hold_d  = 1'b1;
        idle_d       = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      csum_q       <= '0;
      idle_q       <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      addr_q       <= addr_d;
      sum_q        <= sum_d;
      csum_q       <= csum_d;
      idle_q       <= idle_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      busy_q       <= busy_d;
    end
  end

  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign busy       = busy_q;

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (2 ** ADDR_W)
  ) u_ram (
    .clk   (Clk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (bus.rx_data),
    .raddr (bus.pc),
    .rdata (bus.instruction)
  );

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and randomized frame checks of imem_loader against a memory image model
module tb_imem_loader;
  import mcu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic core_hold, load_done, load_error, busy;

  imem_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  imem_loader #(
    .ADDR_W         (8),
    .DATA_W         (8),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .bus        (bus),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Expected RAM image: only addresses the bench has written are known.
  logic [7:0] mm [256];
  bit         mvalid [256];
  logic [7:0] fdata [$];

  always @(negedge clk) if (load_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input logic [7:0] p);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.pc       = p;
    #1;
    if (mvalid[p]) chk("read_before_write", bus.instruction, mm[p]);
    while (bus.rx_ready !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("ready_within_bound", 32'(n < 4), 1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] len_byte, input bit bad, input int gap_max);
    int n;
    int d0;
    logic [7:0] sum;
    logic [7:0] cs;
    n   = (len_byte == 8'h00) ? 256 : int'(len_byte);
    sum = 8'h00;
    for (int i = 0; i < n; i++) sum = sum + fdata[i];
    d0 = done_cnt;
    send_byte(8'hA5, 8'h00);
    chk("sync_busy", busy, 1);
    chk("sync_hold", core_hold, 1);
    chk("sync_err_clear", load_error, 0);
    idle($urandom_range(0, gap_max));
    send_byte(len_byte, 8'h00);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, gap_max));
      send_byte(fdata[i], 8'(i));
      mm[i]     = fdata[i];
      mvalid[i] = 1'b1;
      chk("write_visible", bus.instruction, fdata[i]);
    end
    cs = bad ? sum + 8'($urandom_range(1, 255)) : sum;
    idle($urandom_range(0, gap_max));
    send_byte(cs, 8'h00);
    chk("commit_stall", bus.rx_ready, 0);
    chk("commit_busy", busy, 1);
    @(negedge clk);
    chk("done_pulse", load_done, 32'(!bad));
    chk("hold_after", core_hold, 32'(bad));
    chk("error_after", load_error, 32'(bad));
    chk("busy_after", busy, 0);
    idle(2);
    chk("done_count", 32'(done_cnt - d0), bad ? 0 : 1);
    chk("error_sticky", load_error, 32'(bad));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.pc       = 8'h00;
    for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;

    // Reset values
    rst = 1'b1;
    idle(3);
    chk("rst_hold", core_hold, 1);
    chk("rst_done", load_done, 0);
    chk("rst_error", load_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.rx_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus.rx_ready, 1);
    @(negedge clk);

    // Basic three-byte image
    fdata = '{8'h11, 8'h22, 8'h33};
    run_frame(8'h03, 1'b0, 0);
    bus.pc = 8'h01;
    #1;
    chk("pc1_instr", bus.instruction, 8'h22);
    @(negedge clk);

    // Bad checksum, then a good frame clears the error
    fdata = '{8'h10, 8'h20};
    run_frame(8'h02, 1'b1, 0);
    fdata = '{8'h5C, 8'h01, 8'hFE, 8'h77};
    run_frame(8'h04, 1'b0, 1);

    // Full-depth image, addresses wrap
    fdata = {};
    for (int i = 0; i < 256; i++) fdata.push_back(8'(i));
    run_frame(8'h00, 1'b0, 0);

    // Timeout after 1024 idle cycles inside a frame
    send_byte(8'hA5, 8'h00);
    send_byte(8'h04, 8'h00);
    send_byte(8'h01, 8'h00);
    mm[0] = 8'h01;
    idle(1023);
    chk("tmo_busy_before", busy, 1);
    chk("tmo_err_before", load_error, 0);
    idle(1);
    chk("tmo_busy", busy, 0);
    chk("tmo_error", load_error, 1);
    chk("tmo_hold", core_hold, 1);
    chk("tmo_ready", bus.rx_ready, 1);
    bus.pc = 8'h00;
    #1;
    chk("tmo_no_rollback", bus.instruction, 8'h01);
    @(negedge clk);

    // Leading garbage ignored, sync value accepted as data
    send_byte(8'h00, 8'h00);
    send_byte(8'h5A, 8'h00);
    chk("garbage_idle", busy, 0);
    fdata = '{8'hA5};
    run_frame(8'h01, 1'b0, 0);

    // Reset in the middle of a frame
    send_byte(8'hA5, 8'h00);
    send_byte(8'h04, 8'h00);
    send_byte(8'hC1, 8'h00);
    mm[0] = 8'hC1;
    send_byte(8'hC2, 8'h01);
    mm[1] = 8'hC2;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hold", core_hold, 1);
    chk("mid_rst_error", load_error, 0);
    chk("mid_rst_ready", bus.rx_ready, 0);
    rst = 1'b0;
    bus.pc = 8'h01;
    #1;
    chk("mid_rst_mem_kept", bus.instruction, 8'hC2);
    @(negedge clk);
    fdata = '{8'h0D, 8'hE0, 8'hAD, 8'hBE};
    run_frame(8'h04, 1'b0, 0);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      int nlen;
      int garb;
      logic [7:0] g;
      garb = $urandom_range(0, 3);
      for (int k = 0; k < garb; k++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 8'h00);
      end
      nlen  = $urandom_range(1, 48);
      fdata = {};
      for (int i = 0; i < nlen; i++) fdata.push_back(8'($urandom_range(0, 255)));
      run_frame(8'(nlen), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    // Final sweep of every known address
    for (int a = 0; a < 256; a++) begin
      if (mvalid[a]) begin
        bus.pc = 8'(a);
        #1;
        chk("final_sweep", bus.instruction, mm[a]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction memory for the 8-bit MCU, together with the byte-stream loader that fills it. A host such as a UART receiver sends a framed program image over a valid/ready byte interface, and the loader writes it into a 256×8 memory. The MCU's program counter reads this memory asynchronously to feed the instruction register. While no valid image is present, the block holds the core in reset through `core_hold`.

## Interface
- `ADDR_W`, 8, address width; memory depth is 2^ADDR_W and matches the PC width.
- `DATA_W`, 8, instruction and byte width.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT_CYCLES`, 1024, maximum idle cycles between bytes inside a frame.
- `Clk`  in  1  single clock; all state changes on its rising edge.
- `Reset`  in  1  reset, synchronous and active-high.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts the byte this cycle.
- `pc`  in  ADDR_W  read address, driven by the MCU current PC.
- `instruction`  out  DATA_W  memory word at `pc`; combinational read.
- `core_hold`  out  1  drives the MCU Reset/resetPC; high whenever the image is absent or invalid.
- `load_done`  out  1  one-cycle pulse when a frame is committed successfully.
- `load_error`  out  1  sticky; set on checksum mismatch or timeout.
- `busy`  out  1  high while a frame is in progress (any state except IDLE).

## Operation
- Frame format: `SYNC_BYTE`, then LEN, then LEN data bytes, then CSUM.
  - LEN = 0 means 256 bytes (2^ADDR_W).
  - CSUM equals the sum of the data bytes mod 256.
- A transfer occurs on any edge where `rx_valid && rx_ready` is true.
- FSM states: IDLE, LEN, DATA, CSUM, COMMIT.
  - IDLE: bytes other than `SYNC_BYTE` are accepted and discarded. On `SYNC_BYTE`: go to LEN, set `core_hold`=1, clear `load_error`.
  - LEN: latch the count, clear the address and running sum, go to DATA.
  - DATA: each accepted byte is written to mem[addr]; addr increments and the sum accumulates mod 256. After the last byte, go to CSUM.
  - CSUM: latch the received checksum, go to COMMIT.
  - COMMIT: lasts one cycle with `rx_ready`=0.
    - On match: `load_done`=1 and `core_hold`=0.
    - On mismatch: `load_error`=1 and `core_hold` stays 1.
    - Then return to IDLE.
- `rx_ready` is 1 in every state except COMMIT and the reset cycle.
- Timeout: in LEN, DATA, and CSUM, an idle counter clears on each accepted byte and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, set `load_error`, keep `core_hold`=1.
  - Memory already written is not rolled back.
- Address wrap: with LEN=0, 256 writes cover 0x00..0xFF with no overflow into the FSM.
- A `SYNC_BYTE` value received inside DATA is treated as data, not as a resync.
- The memory has no reset, and its contents are undefined after power-up. Addresses beyond a short image retain their previous contents.

## Timing
- Values while Reset is high, visible on the edge after assertion: state=IDLE, `core_hold`=1, `load_done`=0, `load_error`=0, `busy`=0, `rx_ready`=0, counters=0.
- `rx_ready`=1 from the first cycle after Reset deasserts.
- Reset asserted mid-frame aborts the frame in that cycle; memory is not cleared.
- A write to mem[a] on edge k is visible on `instruction` (with `pc`=a) after edge k. Same-cycle read of the address being written returns the old value.
- Latency from the CSUM byte accepted (edge k): COMMIT during cycle k+1; `load_done` and `core_hold` change on edge k+1 and are visible in cycle k+2.
- `load_done` lasts exactly one cycle. `load_error` remains set until the next accepted `SYNC_BYTE` or Reset.
- Throughput: one byte per cycle, plus one stall cycle per frame.

## Structure
- Shared package `mcu_pkg`:
  - FSM state enum `loader_state_t` (IDLE, LEN, DATA, CSUM, COMMIT).
  - `SYNC_BYTE` default.
  - `IMEM_DEPTH` = 2^ADDR_W.
- Sub-module `imem_ram`:
  - 2^ADDR_W×DATA_W memory.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
- The loader FSM, counters, checksum, and timeout logic live in `imem_loader`.

## Test plan
- Reset, then stream A5, 03, 11, 22, 33, 66 -> mem[0..2] = 11/22/33; `load_done` pulses once; `core_hold` falls; `instruction` = 0x22 with `pc`=1.
- Stream A5, 02, 10, 20, 31 (bad checksum) -> `load_error`=1, `core_hold` stays 1, no `load_done`; a following good frame clears the error.
- Stream A5, 00, then bytes 0x00..0xFF, then CSUM 0x80 -> all 256 locations written with mem[i]=i; `load_done` pulses; address wraps cleanly.
- Stream A5, 04, 01, then idle for 1024 cycles -> FSM returns to IDLE, `load_error`=1, `busy`=0, `core_hold`=1.
- Stream 00, 5A, A5, 01, A5, A5 -> leading bytes ignored; mem[0]=A5; checksum valid; `load_done` pulses.
- Assert Reset after the 2nd data byte of a 4-byte frame -> `busy`=0, `core_hold`=1, `load_error`=0 next cycle; a fresh frame then loads correctly.
